// File: rtl/memory_pipelined.sv
// Single-port word RAM with valid/ready request/response channels, byte strobes,
// a READ_LATENCY-deep pipeline and an in-order response buffer. Optional macro: MEM_RANGE_CHECK_EN.
module memory_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 16,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = READ_LATENCY + 1
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_ReqValid,
    output logic                    o_ReqReady,
    input  logic                    i_ReqWrite,
    input  logic [DATA_WIDTH/8-1:0] i_ReqByteEn,
    input  logic [ADDR_WIDTH-1:0]   i_ReqAddress,
    input  logic [DATA_WIDTH-1:0]   i_ReqData,
    output logic                    o_RespValid,
    input  logic                    i_RespReady,
    output logic [DATA_WIDTH-1:0]   o_RespData,
    output logic                    o_RespWrite,
    output logic                    o_RespError
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WORDS      = 1 << DEPTH_LOG2;
    localparam int CREDIT_W   = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(RESP_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  write_en;
    logic                  range_error;
    logic [DEPTH_LOG2-1:0] index;
    logic [DATA_WIDTH-1:0] stored_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] resp_word;
    logic [CREDIT_W-1:0]   credits;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data  [READ_LATENCY];
    logic                    pipe_write [READ_LATENCY];
    logic                    pipe_error [READ_LATENCY];

    logic [DATA_WIDTH-1:0] rb_data  [RESP_DEPTH];
    logic                  rb_write [RESP_DEPTH];
    logic                  rb_error [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CREDIT_W-1:0]   rb_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both in-flight and buffered responses, so the buffer can never overflow.
    assign accept     = i_ReqValid && o_ReqReady;
    assign pop        = o_RespValid && i_RespReady;
    assign push       = pipe_valid[READ_LATENCY-1];
    assign o_ReqReady = !i_Reset && (credits < CREDIT_MAX);
    assign index      = i_ReqAddress[DEPTH_LOG2-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign range_error = |(i_ReqAddress >> DEPTH_LOG2);
`else
    logic unused_upper_address;
    assign range_error          = 1'b0;
    assign unused_upper_address = ^(i_ReqAddress >> DEPTH_LOG2);
`endif

    assign stored_word = mem[index];

    always_comb begin
        merged_word = stored_word;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (i_ReqByteEn[k]) begin
                merged_word[8*k +: 8] = i_ReqData[8*k +: 8];
            end
        end
    end

    assign resp_word = range_error ? '0 : (i_ReqWrite ? merged_word : stored_word);
    assign write_en  = accept && i_ReqWrite && !range_error;

    always_ff @(posedge i_Clock) begin
        if (write_en) begin
            mem[index] <= merged_word;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            credits <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end
        end
    end

    // Payload stages carry no reset; only the valid bits decide what reaches the buffer.
    always_ff @(posedge i_Clock) begin
        pipe_data[0]  <= resp_word;
        pipe_write[0] <= i_ReqWrite;
        pipe_error[0] <= range_error;
        for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_data[s]  <= pipe_data[s-1];
            pipe_write[s] <= pipe_write[s-1];
            pipe_error[s] <= pipe_error[s-1];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            rb_data[wr_ptr]  <= pipe_data[READ_LATENCY-1];
            rb_write[wr_ptr] <= pipe_write[READ_LATENCY-1];
            rb_error[wr_ptr] <= pipe_error[READ_LATENCY-1];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rb_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   rb_count <= rb_count + 1'b1;
                2'b01:   rb_count <= rb_count - 1'b1;
                default: rb_count <= rb_count;
            endcase
        end
    end

    // Outputs are forced to zero while empty so stale buffer contents never leak after reset.
    assign o_RespValid = (rb_count != '0);
    assign o_RespData  = o_RespValid ? rb_data[rd_ptr]  : '0;
    assign o_RespWrite = o_RespValid ? rb_write[rd_ptr] : 1'b0;
    assign o_RespError = o_RespValid ? rb_error[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_memory_pipelined.sv
// Scoreboard bench for memory_pipelined: reference memory model predicts each response at
// acceptance; a negedge monitor pops and compares, and checks hold-stability and latency.
module tb_memory_pipelined;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int DL  = 16;
    localparam int LAT = 3;
    localparam int RD  = LAT + 1;

    logic          i_Clock = 1'b0;
    logic          i_Reset;
    logic          i_ReqValid;
    logic          o_ReqReady;
    logic          i_ReqWrite;
    logic [3:0]    i_ReqByteEn;
    logic [AW-1:0] i_ReqAddress;
    logic [DW-1:0] i_ReqData;
    logic          o_RespValid;
    logic          i_RespReady;
    logic [DW-1:0] o_RespData;
    logic          o_RespWrite;
    logic          o_RespError;

    always #5 i_Clock = ~i_Clock;

    memory_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL),
        .READ_LATENCY(LAT), .RESP_DEPTH(RD)
    ) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_ReqValid(i_ReqValid), .o_ReqReady(o_ReqReady),
        .i_ReqWrite(i_ReqWrite), .i_ReqByteEn(i_ReqByteEn),
        .i_ReqAddress(i_ReqAddress), .i_ReqData(i_ReqData),
        .o_RespValid(o_RespValid), .i_RespReady(i_RespReady),
        .o_RespData(o_RespData), .o_RespWrite(o_RespWrite), .o_RespError(o_RespError)
    );

    typedef struct {
        logic [31:0] data;
        logic        write;
        logic        error;
        int          accept_edge;
        bit          strict;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int unsigned];
    int          checks = 0;
    int          errors = 0;
    int          edge_count = 0;
    int          accept_count = 0;
    bit          strict_mode = 1'b0;
    bit          rand_done = 1'b0;

    always @(posedge i_Clock) edge_count <= edge_count + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: plain word array, byte merge by masking, optional range rule.
    task automatic model_request(input logic write, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] data, output exp_t e);
        int unsigned idx;
        bit          oor;
        bit          range_on;
        logic [31:0] w;
        logic [31:0] mask;
        idx = addr % 65536;
        oor = (addr / 65536) != 0;
`ifdef MEM_RANGE_CHECK_EN
        range_on = 1'b1;
`else
        range_on = 1'b0;
`endif
        e.write       = write;
        e.error       = range_on && oor;
        e.strict      = strict_mode;
        e.accept_edge = edge_count + 1;
        if (e.error) begin
            e.data = 32'h0;
        end else begin
            w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            if (write) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) begin
                        mask = 32'hFF << (8 * k);
                        w = (w & ~mask) | (data & mask);
                    end
                end
                ref_mem[idx] = w;
            end
            e.data = w;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic apply_stimulus(input logic write, input logic [3:0] be, input logic [31:0] addr,
                                  input logic [31:0] data);
        bit   done;
        exp_t e;
        done         = 1'b0;
        i_ReqValid   = 1'b1;
        i_ReqWrite   = write;
        i_ReqByteEn  = be;
        i_ReqAddress = addr;
        i_ReqData    = data;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge i_Clock);
            if (o_ReqReady) begin
                model_request(write, be, addr, data, e);
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge i_Clock);
            #1;
        end
        i_ReqValid = 1'b0;
        if (!done) check_output("req_accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && (exp_q.size() != 0 || o_RespValid); t++) begin
            @(negedge i_Clock);
        end
        check_output("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge i_Clock);
        #1;
    endtask

    bit          seen = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_data;
    logic        held_write;
    logic        held_error;

    always @(negedge i_Clock) begin
        exp_t e;
        if (i_Reset) begin
            seen = 1'b0;
            held = 1'b0;
        end else begin
            if (i_ReqValid && o_ReqReady) accept_count++;
            if (held && !o_RespValid) begin
                check_output("resp_valid_dropped", 64'(o_RespValid), 64'd1);
                held = 1'b0;
            end
            if (o_RespValid) begin
                if (held) begin
                    check_output("hold_data", 64'(o_RespData), 64'(held_data));
                    check_output("hold_write", 64'(o_RespWrite), 64'(held_write));
                    check_output("hold_error", 64'(o_RespError), 64'(held_error));
                end
                if (exp_q.size() == 0) begin
                    check_output("resp_without_request", 64'(exp_q.size()), 64'd1);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (exp_q[0].strict)
                            check_output("latency_edge", 64'(edge_count), 64'(exp_q[0].accept_edge + LAT));
                    end
                    if (i_RespReady) begin
                        e = exp_q.pop_front();
                        check_output("resp_data", 64'(o_RespData), 64'(e.data));
                        check_output("resp_write", 64'(o_RespWrite), 64'(e.write));
                        check_output("resp_error", 64'(o_RespError), 64'(e.error));
                        seen = 1'b0;
                        held = 1'b0;
                    end else begin
                        held       = 1'b1;
                        held_data  = o_RespData;
                        held_write = o_RespWrite;
                        held_error = o_RespError;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start;
        logic [31:0] addr;
        i_Reset      = 1'b1;
        i_ReqValid   = 1'b0;
        i_ReqWrite   = 1'b0;
        i_ReqByteEn  = 4'h0;
        i_ReqAddress = '0;
        i_ReqData    = '0;
        i_RespReady  = 1'b1;

        repeat (3) begin
            @(negedge i_Clock);
            check_output("ready_in_reset", 64'(o_ReqReady), 64'd0);
        end
        @(posedge i_Clock);
        #1 i_Reset = 1'b0;
        @(negedge i_Clock);
        check_output("ready_after_reset", 64'(o_ReqReady), 64'd1);
        check_output("valid_after_reset", 64'(o_RespValid), 64'd0);
        check_output("data_after_reset", 64'(o_RespData), 64'd0);
        check_output("write_after_reset", 64'(o_RespWrite), 64'd0);
        check_output("error_after_reset", 64'(o_RespError), 64'd0);
        @(posedge i_Clock);
        #1;

        strict_mode = 1'b1;
        for (int a = 0; a < 64; a++) apply_stimulus(1'b1, 4'hF, 32'(a), $urandom);
        apply_stimulus(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        apply_stimulus(1'b0, 4'h0, 32'h10, 32'h0);
        apply_stimulus(1'b1, 4'b0101, 32'h10, 32'h11223344);
        apply_stimulus(1'b0, 4'h0, 32'h10, 32'h0);
        apply_stimulus(1'b0, 4'h0, 32'h5, 32'h0);
        apply_stimulus(1'b1, 4'hF, 32'h5, 32'hCAFEF00D);
        apply_stimulus(1'b0, 4'h0, 32'h5, 32'h0);
        apply_stimulus(1'b1, 4'h0, 32'h6, 32'hFFFFFFFF);
        apply_stimulus(1'b1, 4'hF, 32'h0001_0000, 32'h12345678);
        apply_stimulus(1'b0, 4'h0, 32'h0, 32'h0);
        wait_drain();

        strict_mode = 1'b0;
        i_RespReady = 1'b0;
        start = accept_count;
        fork
            begin
                for (int a = 0; a < 8; a++) apply_stimulus(1'b0, 4'h0, 32'(a), 32'h0);
            end
            begin
                repeat (10) @(negedge i_Clock);
                check_output("bp_accepts", 64'(accept_count - start), 64'(RD));
                check_output("bp_ready_low", 64'(o_ReqReady), 64'd0);
                check_output("bp_valid_high", 64'(o_RespValid), 64'd1);
                @(posedge i_Clock);
                #1 i_RespReady = 1'b1;
            end
        join
        wait_drain();

        i_RespReady = 1'b0;
        apply_stimulus(1'b0, 4'h0, 32'h3, 32'h0);
        apply_stimulus(1'b0, 4'h0, 32'h4, 32'h0);
        i_Reset      = 1'b1;
        i_ReqValid   = 1'b1;
        i_ReqWrite   = 1'b1;
        i_ReqByteEn  = 4'hF;
        i_ReqAddress = 32'h7;
        i_ReqData    = ~ref_mem[7];
        @(negedge i_Clock);
        check_output("ready_during_midreset", 64'(o_ReqReady), 64'd0);
        @(posedge i_Clock);
        #1;
        i_Reset    = 1'b0;
        i_ReqValid = 1'b0;
        exp_q.delete();
        i_RespReady = 1'b1;
        @(negedge i_Clock);
        check_output("valid_after_midreset", 64'(o_RespValid), 64'd0);
        check_output("ready_after_midreset", 64'(o_ReqReady), 64'd1);
        @(posedge i_Clock);
        #1;
        strict_mode = 1'b1;
        apply_stimulus(1'b0, 4'h0, 32'h7, 32'h0);
        wait_drain();

        strict_mode = 1'b0;
        fork
            begin
                while (!rand_done) begin
                    @(posedge i_Clock);
                    #1 i_RespReady = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge i_Clock);
                        #1;
                    end
                    addr = 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 7) == 0) addr[31:16] = 16'($urandom_range(1, 65535));
                    apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
                end
                rand_done = 1'b1;
            end
        join
        i_RespReady = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
